alu_arbiter: RTL and testbench

Two-port scheduler that shares one 8-bit ALU (add/sub/mul/div, 2-bit opSel, carry-in) between two requesters, such as the execute stage and a address/branch helper.
- Arbitrates valid/ready requests round-robin.
- Latches the granted operands and drives the ALU through registered outputs.
- Holds operands for a configurable number of cycles, captures the result, and returns it on a per-requester response handshake.
- Sits between the requesters and the combinational ALU instance.

---
 rtl/alu_arbiter.sv | 170 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin two-port scheduler driving a shared combinational ALU
// Optional: define ALU_ARB_DIV0_CHECK_EN to answer divide-by-zero with an error response.
module alu_arbiter #(
  parameter int WIDTH       = 8,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  input  logic             req1_cin,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_cout,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [1:0]       alu_opSel,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_cout,
  output logic             busy,
  output logic             grant_id
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic             grant_q, grant_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [1:0]       op_q, op_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  logic             any_req, pick, div0;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [1:0]       sel_op;
  logic             sel_cin;

  // Round-robin only matters on contention; a lone requester always wins.
  always_comb begin
    any_req = req0_valid | req1_valid;
    pick    = (req0_valid & req1_valid) ? rr_q : req1_valid;
    sel_a   = pick ? req1_a   : req0_a;
    sel_b   = pick ? req1_b   : req0_b;
    sel_op  = pick ? req1_op  : req0_op;
    sel_cin = pick ? req1_cin : req0_cin;
  end

`ifdef ALU_ARB_DIV0_CHECK_EN
  assign div0 = (sel_op == 2'b11) && (sel_b == '0);
`else
  assign div0 = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    op_d       = op_q;
    cin_d      = cin_q;
    res_d      = res_q;
    cout_d     = cout_q;
    err_d      = err_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          req0_ready = ~pick;
          req1_ready = pick;
          grant_d    = pick;
          if (div0) begin
            // ALU operands are left untouched; the response is synthesised here.
            res_d   = '1;
            cout_d  = 1'b0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            in1_d   = sel_a;
            in2_d   = sel_b;
            op_d    = sel_op;
            cin_d   = sel_cin;
            err_d   = 1'b0;
            cnt_d   = CNT_INIT;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          res_d   = alu_res;
          cout_d  = alu_cout;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (grant_q ? rsp1_ready : rsp0_ready) begin
          rr_d    = ~grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      grant_q <= 1'b0;
      cnt_q   <= 4'd0;
      in1_q   <= '0;
      in2_q   <= '0;
      op_q    <= 2'b00;
      cin_q   <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      op_q    <= op_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign rsp0_valid = (state_q == RESP) && !grant_q;
  assign rsp1_valid = (state_q == RESP) && grant_q;
  assign rsp_res    = res_q;
  assign rsp_cout   = cout_q;
  assign rsp_err    = err_q;
  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign alu_opSel  = op_q;
  assign alu_cin    = cin_q;
  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed scoreboard bench for alu_arbiter (EXEC_CYCLES 1 and 4 instances)
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [7:0] rsp_res, alu_in1, alu_in2, alu_res;
  logic       rsp_cout, rsp_err, alu_cin, alu_cout, busy, grant_id;
  logic [1:0] alu_opSel;

  logic       x_req0_valid, x_req0_ready, x_req0_cin, x_req1_ready;
  logic [7:0] x_req0_a, x_req0_b;
  logic [1:0] x_req0_op;
  logic       x_rsp0_valid, x_rsp1_valid, x_rsp_cout, x_rsp_err, x_alu_cin, x_alu_cout;
  logic       x_busy, x_grant_id;
  logic [7:0] x_rsp_res, x_alu_in1, x_alu_in2, x_alu_res;
  logic [1:0] x_alu_opSel;

  // Reference ALU: add/sub with carry/borrow, low-byte multiply with overflow flag, div (x/0 -> FF).
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] op, input logic cin);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b} + {8'b0, cin};
      2'b01:   return {1'b0, a} - {1'b0, b} - {8'b0, cin};
      2'b10:   return {|p[15:8], p[7:0]};
      default: return (b == 8'h00) ? 9'h0FF : {1'b0, a / b};
    endcase
  endfunction

  assign {alu_cout, alu_res}     = alu_f(alu_in1, alu_in2, alu_opSel, alu_cin);
  assign {x_alu_cout, x_alu_res} = alu_f(x_alu_in1, x_alu_in2, x_alu_opSel, x_alu_cin);

  alu_arbiter #(.WIDTH(8), .EXEC_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_res(rsp_res), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opSel(alu_opSel), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_cout(alu_cout), .busy(busy), .grant_id(grant_id)
  );

  alu_arbiter #(.WIDTH(8), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(x_req0_valid), .req0_ready(x_req0_ready), .req0_a(x_req0_a), .req0_b(x_req0_b),
    .req0_op(x_req0_op), .req0_cin(x_req0_cin),
    .req1_valid(1'b0), .req1_ready(x_req1_ready), .req1_a(8'h00), .req1_b(8'h00),
    .req1_op(2'b00), .req1_cin(1'b0),
    .rsp0_valid(x_rsp0_valid), .rsp0_ready(1'b1),
    .rsp1_valid(x_rsp1_valid), .rsp1_ready(1'b1),
    .rsp_res(x_rsp_res), .rsp_cout(x_rsp_cout), .rsp_err(x_rsp_err),
    .alu_in1(x_alu_in1), .alu_in2(x_alu_in2), .alu_opSel(x_alu_opSel), .alu_cin(x_alu_cin),
    .alu_res(x_alu_res), .alu_cout(x_alu_cout), .busy(x_busy), .grant_id(x_grant_id)
  );

  typedef struct {
    logic       id;
    logic [7:0] res;
    logic       cout;
    logic       err;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: latency on each response rise, payload on each response handshake.
  int   cyc_n = 0;
  int   acc_t [2];
  logic pv [2];
  always @(negedge clk) begin
    logic v [2];
    logic r [2];
    exp_t e;
    cyc_n++;
    v[0] = rsp0_valid; v[1] = rsp1_valid;
    r[0] = rsp0_ready; r[1] = rsp1_ready;
    if (rst) begin
      pv[0] = 1'b0; pv[1] = 1'b0;
    end else begin
      if (req0_valid && req0_ready) acc_t[0] = cyc_n;
      if (req1_valid && req1_ready) acc_t[1] = cyc_n;
      for (int i = 0; i < 2; i++) begin
        if (v[i] && !pv[i]) begin
          if (sb.size() == 0) chk("rsp_unexpected", 32'(v[i]), 32'd0);
          else begin
            chk("rsp_latency", 32'(cyc_n - acc_t[i]), 32'(sb[0].lat));
            chk("rsp_channel", 32'(i), 32'(sb[0].id));
          end
        end
        if (v[i] && r[i] && sb.size() != 0) begin
          e = sb.pop_front();
          chk("rsp_id", 32'(i), 32'(e.id));
          chk("rsp_res", 32'(rsp_res), 32'(e.res));
          chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
      pv[0] = v[0]; pv[1] = v[1];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_rsp(input logic id, input logic [7:0] res, input logic cout,
                            input logic err, input int lat);
    exp_t e;
    e.id = id; e.res = res; e.cout = cout; e.err = err; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic drive(input logic id, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic cin);
    if (id) begin
      req1_a = a; req1_b = b; req1_op = op; req1_cin = cin; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_op = op; req0_cin = cin; req0_valid = 1'b1;
    end
  endtask

  task automatic wait_accept(input logic id, input string tag, output int waited);
    waited = 0;
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk(tag, 32'(id ? req1_ready : req0_ready), 32'd1);
    @(posedge clk);
    #2;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy || sb.size() != 0), 32'd0);
    cyc();
  endtask

  initial begin
    int w, lat;
    logic [7:0] s1, s2;
    logic [1:0] sop;
    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; req0_cin = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; req1_cin = 0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    x_req0_valid = 0; x_req0_a = 0; x_req0_b = 0; x_req0_op = 0; x_req0_cin = 0;
    cyc(); cyc();
    chk("reset_state", {busy, grant_id, rsp0_valid, rsp1_valid, rsp_err, rsp_cout},
        32'd0);
    chk("reset_data", {alu_in1, alu_in2, alu_opSel, alu_cin, rsp_res}, 32'd0);
    rst = 1'b0;
    cyc();

    // single add, ready on the first cycle
    expect_rsp(0, 8'hAB, 1'b0, 1'b0, 2);
    drive(0, 8'hAA, 8'h01, 2'b00, 1'b0);
    wait_accept(0, "t1_accept", w);
    chk("t1_ready_first_cycle", 32'(w), 32'd0);
    wait_idle("t1_done");
    chk("t1_busy_low", 32'(busy), 32'd0);

    // EXEC_CYCLES=4 instance: operands held 4 cycles, response 5 cycles after accept
    x_req0_a = 8'h01; x_req0_b = 8'h01; x_req0_op = 2'b00; x_req0_cin = 1'b0; x_req0_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!x_req0_ready && w < 20) begin @(negedge clk); w++; end
    chk("t4_accept", 32'(x_req0_ready), 32'd1);
    @(posedge clk); #2;
    x_req0_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!x_rsp0_valid && lat < 20) begin
      chk("t4_alu_hold", {x_alu_in1, x_alu_in2, x_alu_opSel, x_alu_cin}, {8'h01, 8'h01, 2'b00, 1'b0});
      @(negedge clk);
      lat++;
    end
    chk("t4_latency", 32'(lat), 32'd5);
    chk("t4_res", {x_rsp_err, x_rsp_cout, x_rsp_res}, {1'b0, 1'b0, 8'h02});
    cyc(); cyc();

    // contention from reset: req0 first, then req1
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    expect_rsp(0, 8'hA9, 1'b0, 1'b0, 2);
    expect_rsp(1, 8'h0C, 1'b0, 1'b0, 2);
    drive(0, 8'hAA, 8'h01, 2'b01, 1'b0);
    drive(1, 8'h03, 8'h04, 2'b10, 1'b0);
    wait_accept(0, "t2_req0_first", w);
    wait_accept(1, "t2_req1_second", w);
    wait_idle("t2_pair_done");

    // carry-out boundary on a lone req0, leaves the pointer on req1
    expect_rsp(0, 8'h01, 1'b1, 1'b0, 2);
    drive(0, 8'hFF, 8'h01, 2'b00, 1'b1);
    wait_accept(0, "t2_lone_req0", w);
    wait_idle("t2_lone_done");

    // second contention: req1 wins now
    expect_rsp(1, 8'hFF, 1'b1, 1'b0, 2);
    expect_rsp(0, 8'h00, 1'b1, 1'b0, 2);
    drive(1, 8'h00, 8'h01, 2'b01, 1'b0);
    drive(0, 8'h10, 8'h10, 2'b10, 1'b0);
    wait_accept(1, "t2_req1_first", w);
    wait_accept(0, "t2_req0_second", w);
    wait_idle("t2_pair2_done");

    // response stall on req1 while req0 waits
    rsp1_ready = 1'b0;
    expect_rsp(1, 8'h08, 1'b0, 1'b0, 2);
    expect_rsp(0, 8'h46, 1'b0, 1'b0, 2);
    drive(1, 8'h10, 8'h02, 2'b11, 1'b0);
    drive(0, 8'h12, 8'h34, 2'b00, 1'b0);
    wait_accept(1, "t3_accept", w);
    w = 0;
    @(negedge clk);
    while (!rsp1_valid && w < 10) begin @(negedge clk); w++; end
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall", {rsp1_valid, rsp0_valid, req0_ready, rsp_res}, {1'b1, 1'b0, 1'b0, 8'h08});
      @(negedge clk);
    end
    cyc();
    rsp1_ready = 1'b1;
    wait_accept(0, "t3_req0_after", w);
    wait_idle("t3_done");

    // reset during EXEC abandons the operation
    drive(0, 8'h05, 8'h06, 2'b00, 1'b0);
    wait_accept(0, "t5_accept", w);
    rst = 1'b1;
    #1;
    chk("t5_async_clear", {busy, rsp0_valid, rsp1_valid, grant_id, alu_in1, alu_in2}, 32'd0);
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", 32'(rsp0_valid | rsp1_valid | busy), 32'd0);
    end
    cyc();
    expect_rsp(0, 8'h0B, 1'b0, 1'b0, 2);
    drive(0, 8'h05, 8'h06, 2'b00, 1'b0);
    wait_accept(0, "t5_after_reset", w);
    wait_idle("t5_done");

    // divide by zero
    s1 = alu_in1; s2 = alu_in2; sop = alu_opSel;
`ifdef ALU_ARB_DIV0_CHECK_EN
    expect_rsp(0, 8'hFF, 1'b0, 1'b1, 1);
`else
    expect_rsp(0, 8'hFF, 1'b0, 1'b0, 2);
`endif
    drive(0, 8'h10, 8'h00, 2'b11, 1'b0);
    wait_accept(0, "t6_accept", w);
`ifdef ALU_ARB_DIV0_CHECK_EN
    chk("t6_alu_untouched", {alu_in1, alu_in2, alu_opSel}, {s1, s2, sop});
`else
    chk("t6_alu_driven", {alu_in1, alu_in2, alu_opSel}, {8'h10, 8'h00, 2'b11});
`endif
    wait_idle("t6_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
